// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared TX header codes and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    // Width of a TX command header on the memory interface.
    localparam int TX_CMD_BITS = 4;

    // TX header codes understood by memory_interface.
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_NOP      = 4'h0;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 4'h1;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 4'h2;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_ERASE    = 4'h3;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_STATUS   = 4'h4;

    // Only READ headers produce a reply on the RX channel.
    function automatic logic expects_reply(input logic [TX_CMD_BITS-1:0] cmd);
        return cmd == TX_HEADER_READ_16;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory_interface TX/RX channel signals
interface mem_port_arbiter_if #(
    parameter int IO_BITS = 2
);
    import mem_port_arbiter_pkg::*;

    logic                   tx_command_valid;
    logic [TX_CMD_BITS-1:0] tx_command;
    logic [IO_BITS-1:0]     tx_data;
    logic                   tx_command_started;
    logic                   tx_active;
    logic                   tx_data_next;
    logic                   tx_done;
    logic                   rx_started;
    logic                   rx_active;
    logic                   rx_sbs_valid;
    logic                   rx_data_valid;
    logic                   rx_done;

    // Arbiter side: issues commands, observes channel strobes.
    modport master (
        output tx_command_valid,
        output tx_command,
        output tx_data,
        input  tx_command_started,
        input  tx_active,
        input  tx_data_next,
        input  tx_done,
        input  rx_started,
        input  rx_active,
        input  rx_sbs_valid,
        input  rx_data_valid,
        input  rx_done
    );

    // memory_interface side.
    modport slave (
        input  tx_command_valid,
        input  tx_command,
        input  tx_data,
        output tx_command_started,
        output tx_active,
        output tx_data_next,
        output tx_done,
        output rx_started,
        output rx_active,
        output rx_sbs_valid,
        output rx_data_valid,
        output rx_done
    );

endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// rtl/mem_port_arbiter_tag_fifo.sv - in-order FIFO of outstanding read reply tags
module mem_port_arbiter_tag_fifo #(
    parameter int BITS  = 2,
    parameter int DEPTH = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           add,
    input  logic                           remove,
    input  logic [BITS-1:0]                new_entry,
    output logic [BITS-1:0]                head,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_add;
    logic            do_remove;

    // An empty FIFO ignores removes so the count can never underflow; a full
    // FIFO still accepts an add when a remove frees a slot in the same cycle.
    assign do_remove = remove & (count != '0);
    assign do_add    = add & ((count != DEPTH_C) | do_remove);

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH, which need not be a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_add) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_remove) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (do_add && !do_remove) begin
                count <= count + 1'b1;
            end else if (do_remove && !do_add) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents are only observed through head while non-empty.
    always_ff @(posedge clk) begin
        if (do_add) begin
            mem[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory_interface TX/RX channel between several requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ            = 2,
    parameter int IO_BITS         = 2,
    parameter int MAX_OUTSTANDING = 7,
    parameter int ROUND_ROBIN     = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NREQ-1:0]                        req_valid,
    input  logic [NREQ*TX_CMD_BITS-1:0]            req_cmd,
    input  logic [NREQ*IO_BITS-1:0]                req_data,
    input  logic [NREQ-1:0]                        req_reply,
    input  logic [NREQ-1:0]                        req_reserve,
    output logic [NREQ-1:0]                        grant,
    mem_port_arbiter_if.master                     mem,
    output logic [NREQ-1:0]                        g_tx_started,
    output logic [NREQ-1:0]                        g_tx_active,
    output logic [NREQ-1:0]                        g_tx_data_next,
    output logic [NREQ-1:0]                        g_tx_done,
    output logic [NREQ-1:0]                        g_rx_started,
    output logic [NREQ-1:0]                        g_rx_active,
    output logic [NREQ-1:0]                        g_rx_sbs_valid,
    output logic [NREQ-1:0]                        g_rx_data_valid,
    output logic [NREQ-1:0]                        g_rx_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   full,
    output logic                                   rx_orphan
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TAG_W = 1 + IDX_W;

    typedef struct packed {
        logic             reply;
        logic [IDX_W-1:0] owner;
    } tag_entry_t;

    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] rr_cand;
    logic [IDX_W-1:0] cur_owner;
    logic             arb_found;
    logic [NREQ-1:0]  want;
    logic [NREQ-1:0]  owner_onehot;
    logic [NREQ-1:0]  rx_route;
    logic             rx_orphan_q;
    logic             any_rx;
    logic             tag_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic [TAG_W-1:0] fifo_head;
    tag_entry_t       push_entry;
    tag_entry_t       head_entry;

    assign owner_onehot = NREQ'(1) << owner_q;

    // Pick the next TX owner: a reserving owner keeps the channel, otherwise
    // fixed or rotating priority among requesters that want it; with nobody
    // asking the current owner is kept.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = owner_q;
        rr_cand   = '0;
        want      = req_valid | (req_reserve & owner_onehot);
        if (req_reserve[owner_q]) begin
            arb_idx   = owner_q;
            arb_found = 1'b1;
        end else if (ROUND_ROBIN != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                rr_cand = IDX_W'((int'(last_winner) + k) % NREQ);
                if (!arb_found && want[rr_cand]) begin
                    arb_idx   = rr_cand;
                    arb_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!arb_found && want[IDX_W'(k)]) begin
                    arb_idx   = IDX_W'(k);
                    arb_found = 1'b1;
                end
            end
        end
    end

    // While a message is on the wire the grant is frozen to the registered owner;
    // between messages the arbitration result takes effect in the same cycle.
    assign cur_owner = mem.tx_active ? owner_q : arb_idx;
    assign grant     = NREQ'(1) << cur_owner;

    // Command path muxed from the owner; a full tag FIFO holds off every new command,
    // writes included, so replies can never outrun the tag storage.
    assign mem.tx_command_valid = req_valid[cur_owner] & ~fifo_full;
    assign mem.tx_command       = req_cmd[cur_owner*TX_CMD_BITS +: TX_CMD_BITS];
    assign mem.tx_data          = req_data[cur_owner*IO_BITS +: IO_BITS];

    assign g_tx_started   = {NREQ{mem.tx_command_started}} & grant;
    assign g_tx_active    = {NREQ{mem.tx_active}}          & grant;
    assign g_tx_data_next = {NREQ{mem.tx_data_next}}       & grant;
    assign g_tx_done      = {NREQ{mem.tx_done}}            & grant;

    // Owner lock, round-robin history and the sticky orphan-reply flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= '0;
            last_winner <= IDX_W'(NREQ - 1);
            rx_orphan_q <= 1'b0;
        end else begin
            if (!mem.tx_active) begin
                owner_q <= arb_idx;
            end
            if (mem.tx_command_started) begin
                last_winner <= cur_owner;
            end
            if (fifo_empty && any_rx) begin
                rx_orphan_q <= 1'b1;
            end
        end
    end

    assign rx_orphan = rx_orphan_q;

    // Every started READ reserves a reply slot tagged with its owner; the reply
    // bit records whether that owner wants the data or it is to be discarded.
    assign tag_push         = mem.tx_command_started & expects_reply(mem.tx_command);
    assign push_entry.reply = req_reply[cur_owner];
    assign push_entry.owner = cur_owner;

    mem_port_arbiter_tag_fifo #(
        .BITS  (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .add       (tag_push),
        .remove    (mem.rx_done),
        .new_entry (push_entry),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (outstanding)
    );

    assign full       = fifo_full;
    assign head_entry = fifo_head;

    // Replies come back in issue order, so the head tag names the receiver; the
    // head stays put until rx_done, covering the whole reply including rx_active.
    assign any_rx   = mem.rx_started | mem.rx_active | mem.rx_sbs_valid
                    | mem.rx_data_valid | mem.rx_done;
    assign rx_route = (!fifo_empty && head_entry.reply) ? (NREQ'(1) << head_entry.owner) : '0;

    assign g_rx_started    = {NREQ{mem.rx_started}}    & rx_route;
    assign g_rx_active     = {NREQ{mem.rx_active}}     & rx_route;
    assign g_rx_sbs_valid  = {NREQ{mem.rx_sbs_valid}}  & rx_route;
    assign g_rx_data_valid = {NREQ{mem.rx_data_valid}} & rx_route;
    assign g_rx_done       = {NREQ{mem.rx_done}}       & rx_route;

endmodule
